// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words over req/ack into a small FIFO.
// Ports: cpu_clk/cpu_rst, imem_* request side, cpu_instruction* head outputs,
//   cpu_take pop, redirect_valid/redirect_pc flush+restart, queue_count occupancy.
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         cpu_clk,
  input  logic                         cpu_rst,
  output logic                         imem_req,
  output logic [31:0]                  imem_addr,
  input  logic                         imem_ack,
  input  logic [31:0]                  imem_rdata,
  output logic [31:0]                  cpu_instruction,
  output logic [31:0]                  cpu_instruction_pc,
  output logic                         cpu_instruction_RDY_BSY,
  input  logic                         cpu_take,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t        state, state_n;
  logic [31:0]   fetch_pc, fetch_pc_n;
  logic [31:0]   addr_n;
  logic [31:0]   redir_tgt, pc_inc;
  logic [31:0]   q_data [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_n;
  logic          valid, push, pop;

  assign valid     = (count != '0);
  assign pop       = valid & cpu_take & ~redirect_valid;
  assign push      = (state == REQ) & imem_ack & ~redirect_valid;
  assign count_n   = count + CW'(push) - CW'(pop);
  assign redir_tgt = {redirect_pc[31:2], 2'b00};
  assign pc_inc    = fetch_pc + 32'd4;

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    addr_n     = imem_addr;
    if (redirect_valid) begin
      fetch_pc_n = redir_tgt;
      case (state)
        IDLE: begin
          state_n = REQ;
          addr_n  = redir_tgt;
        end
        REQ: begin
          // Without ack the old request must stay stable; drain it first.
          if (imem_ack) begin
            state_n = REQ;
            addr_n  = redir_tgt;
          end else begin
            state_n = DRAIN;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            state_n = REQ;
            addr_n  = redir_tgt;
          end
        end
        default: state_n = IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (count < FULL) begin
            state_n = REQ;
            addr_n  = fetch_pc;
          end
        end
        REQ: begin
          if (imem_ack) begin
            fetch_pc_n = pc_inc;
            // Only reissue if a slot is still free after this push/pop.
            if (count_n < FULL) begin
              state_n = REQ;
              addr_n  = pc_inc;
            end else begin
              state_n = IDLE;
            end
          end
        end
        DRAIN: begin
          // fetch_pc already holds the redirect target.
          if (imem_ack) begin
            state_n = REQ;
            addr_n  = fetch_pc;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_addr <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      imem_addr <= addr_n;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count_n;
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (push) begin
      q_data[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]   <= fetch_pc;
    end
  end

  assign imem_req                = (state != IDLE);
  assign cpu_instruction_RDY_BSY = valid;
  assign cpu_instruction         = valid ? q_data[rd_ptr] : '0;
  assign cpu_instruction_pc      = valid ? q_pc[rd_ptr] : '0;
  assign queue_count             = count;

  a_no_overflow: assert property (
    @(posedge cpu_clk) disable iff (cpu_rst) !(push && (count == FULL))
  );

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Testbench for instr_prefetch_queue: directed sequences with a pc scoreboard.
// Ports: drives all DUT inputs, models a memory that returns a pc-derived word.
module tb_instr_prefetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        rdy;
  logic        take;
  logic        redir;
  logic [31:0] rpc;
  logic [2:0]  qcount;
  logic        ack_en;

  int vecs = 0;
  int errs = 0;
  logic [31:0] exp_q [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_ack   = imem_req & ack_en;
  assign imem_rdata = mem_word(imem_addr);

  instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .cpu_clk                 (clk),
    .cpu_rst                 (rst),
    .imem_req                (imem_req),
    .imem_addr               (imem_addr),
    .imem_ack                (imem_ack),
    .imem_rdata              (imem_rdata),
    .cpu_instruction         (instr),
    .cpu_instruction_pc      (instr_pc),
    .cpu_instruction_RDY_BSY (rdy),
    .cpu_take                (take),
    .redirect_valid          (redir),
    .redirect_pc             (rpc),
    .queue_count             (qcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_req"},   {31'd0, imem_req}, 32'd0);
    chk({nm, "_addr"},  imem_addr, 32'h0);
    chk({nm, "_rdy"},   {31'd0, rdy}, 32'd0);
    chk({nm, "_count"}, {29'd0, qcount}, 32'd0);
    chk({nm, "_instr"}, instr, 32'h0);
    chk({nm, "_pc"},    instr_pc, 32'h0);
  endtask

  task automatic chk_drained(input string nm);
    chk({nm, "_drain"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset;
    rst    = 1'b1;
    redir  = 1'b0;
    take   = 1'b0;
    ack_en = 1'b0;
    step;
    step;
  endtask

  // Monitor: every accepted head word must match the next expected pc.
  always @(negedge clk) begin
    if (!rst && rdy && take && !redir) begin
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_word: got pc %h expected none", instr_pc);
      end else begin
        logic [31:0] epc;
        epc = exp_q.pop_front();
        chk("mon_pc", instr_pc, epc);
        chk("mon_instr", instr, mem_word(epc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; take = 1'b0; redir = 1'b0; rpc = '0; ack_en = 1'b0;
    step;
    step;
    chk_reset_vals("rst0");

    // Streaming with acks every cycle and continuous take.
    ack_en = 1'b1; take = 1'b1; rst = 1'b0;
    for (int k = 0; k < 6; k++) exp_q.push_back(32'(4 * k));
    for (int i = 0; i < 8; i++) begin
      step;
      chk("t1_addr", imem_addr, 32'(4 * i));
      chk("t1_req", {31'd0, imem_req}, 32'd1);
      if (i == 0) chk("t1_rdy0", {31'd0, rdy}, 32'd0);
      if (i == 1) chk("t1_rdy1", {31'd0, rdy}, 32'd1);
    end
    take = 1'b0;
    step;
    step;
    chk("t1_cnt3", {29'd0, qcount}, 32'd3);
    chk("t1_addr24", imem_addr, 32'h24);
    // Asynchronous reset mid-request with three entries held.
    rst = 1'b1;
    #1;
    chk_reset_vals("arst");
    chk_drained("t1");
    step;

    // Fill to capacity with take low, then resume.
    take = 1'b0; ack_en = 1'b1; rst = 1'b0;
    step;
    chk("t2_first_req", {31'd0, imem_req}, 32'd1);
    chk("t2_first_addr", imem_addr, 32'h0);
    repeat (4) step;
    chk("t2_full", {29'd0, qcount}, 32'd4);
    chk("t2_idle", {31'd0, imem_req}, 32'd0);
    repeat (2) step;
    chk("t2_full_hold", {29'd0, qcount}, 32'd4);
    chk("t2_idle_hold", {31'd0, imem_req}, 32'd0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    take = 1'b1;
    step;
    chk("t2_cnt3", {29'd0, qcount}, 32'd3);
    chk("t2_still_idle", {31'd0, imem_req}, 32'd0);
    step;
    chk("t2_resume_req", {31'd0, imem_req}, 32'd1);
    chk("t2_resume_addr", imem_addr, 32'h10);
    take = 1'b0;
    step;
    step;
    chk_drained("t2");

    // Redirect while a request waits for a delayed ack.
    do_reset();
    take = 1'b1; rst = 1'b0;
    step;
    chk("t3_addr0", imem_addr, 32'h0);
    redir = 1'b1; rpc = 32'h103;
    step;
    redir = 1'b0;
    chk("t3_hold_a", imem_addr, 32'h0);
    chk("t3_hold_req", {31'd0, imem_req}, 32'd1);
    step;
    chk("t3_hold_b", imem_addr, 32'h0);
    chk("t3_empty_b", {31'd0, rdy}, 32'd0);
    step;
    chk("t3_hold_c", imem_addr, 32'h0);
    ack_en = 1'b1;
    exp_q.push_back(32'h100);
    step;
    chk("t3_new_addr", imem_addr, 32'h100);
    chk("t3_new_req", {31'd0, imem_req}, 32'd1);
    chk("t3_discard", {29'd0, qcount}, 32'd0);
    step;
    ack_en = 1'b0;
    chk("t3_cnt1", {29'd0, qcount}, 32'd1);
    step;
    chk("t3_cnt0", {29'd0, qcount}, 32'd0);
    chk_drained("t3");

    // Redirect coincident with ack and take, two entries queued.
    do_reset();
    ack_en = 1'b1; rst = 1'b0;
    step;
    step;
    step;
    chk("t4_cnt2", {29'd0, qcount}, 32'd2);
    redir = 1'b1; rpc = 32'h40; take = 1'b1;
    exp_q.push_back(32'h40);
    step;
    redir = 1'b0;
    chk("t4_flush", {29'd0, qcount}, 32'd0);
    chk("t4_rdy0", {31'd0, rdy}, 32'd0);
    chk("t4_addr", imem_addr, 32'h40);
    step;
    ack_en = 1'b0;
    chk("t4_rdy1", {31'd0, rdy}, 32'd1);
    step;
    step;
    chk("t4_cnt0", {29'd0, qcount}, 32'd0);
    chk_drained("t4");

    // Redirect from IDLE near the top of memory; fetch_pc wraps.
    do_reset();
    take = 1'b1; ack_en = 1'b1; rst = 1'b0;
    redir = 1'b1; rpc = 32'hFFFF_FFF8;
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    step;
    redir = 1'b0;
    chk("t5_a0", imem_addr, 32'hFFFF_FFF8);
    step;
    chk("t5_a1", imem_addr, 32'hFFFF_FFFC);
    step;
    chk("t5_a2", imem_addr, 32'h0000_0000);
    step;
    chk("t5_a3", imem_addr, 32'h0000_0004);
    ack_en = 1'b0;
    step;
    step;
    chk("t5_cnt0", {29'd0, qcount}, 32'd0);
    chk_drained("t5");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
